// File: rtl/mem_arb_pkg.sv
// Shared definitions for the memory arbiter slice.
//   - state_t         : arbiter FSM state encoding (also exported for debug)
//   - DEF_AW / DEF_DW : default address / data widths
//   - DEF_MAX_DSTREAK : default limit on back-to-back data grants while fetch waits
//   - streak_w()      : width of a counter that holds 0..max_streak
package mem_arb_pkg;

    localparam int DEF_AW          = 32;
    localparam int DEF_DW          = 32;
    localparam int DEF_MAX_DSTREAK = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        IF_BUSY = 2'd1,
        D_BUSY  = 2'd2
    } state_t;

    function automatic int streak_w(input int max_streak);
        return (max_streak < 2) ? 1 : $clog2(max_streak + 1);
    endfunction

endpackage

// File: rtl/mem_arb_streak.sv
// Saturating counter of consecutive data grants taken while a fetch waits.
// Ports:
//   clk, rst : clock, asynchronous active-high reset
//   inc      : count one more data grant (ignored once at_max)
//   clr      : return to zero (wins over inc)
//   at_max   : count has reached MAX; fetch must be served next
//   count    : current streak value
module mem_arb_streak
    import mem_arb_pkg::*;
#(
    parameter int MAX = DEF_MAX_DSTREAK,
    parameter int CW  = streak_w(MAX)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          inc,
    input  logic          clr,
    output logic          at_max,
    output logic [CW-1:0] count
);

    localparam logic [CW-1:0] MAXV = CW'(MAX);

    assign at_max = (count == MAXV);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && !at_max) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter between instruction fetch (if_*) and the MEM
// stage (d_*). Data normally wins, but after MAX_DSTREAK consecutive data
// grants taken while a fetch was waiting, the fetch is served next.
//
// Handshake: each requester raises *_req with its fields and holds them until
// the matching *_ack pulse (one cycle). The arbiter raises mem_req with
// latched mem_* fields and holds them until mem_ack; mem_ack may arrive in the
// very first mem_req cycle. mem_ack outside a transaction is ignored.
//
// Ports:
//   clk, rst                         : clock, asynchronous active-high reset
//   if_req/if_addr                   : fetch request
//   if_rdata/if_ack/if_stall         : fetch response and stall
//   d_req/d_we/d_addr/d_wdata        : data request (d_we=1 store)
//   d_rdata/d_ack/d_stall            : data response and stall
//   mem_req/mem_we/mem_addr/mem_wdata: request to memory
//   mem_rdata/mem_ack                : memory response
//   dbg_state/dbg_streak             : FSM state and starvation streak
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AW          = DEF_AW,
    parameter int DW          = DEF_DW,
    parameter int MAX_DSTREAK = DEF_MAX_DSTREAK,
    parameter int SW          = streak_w(MAX_DSTREAK)
) (
    input  logic          clk,
    input  logic          rst,
    // fetch port
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic [DW-1:0] if_rdata,
    output logic          if_ack,
    output logic          if_stall,
    // data port
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic [DW-1:0] d_rdata,
    output logic          d_ack,
    output logic          d_stall,
    // memory port
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_ack,
    // debug
    output state_t        dbg_state,
    output logic [SW-1:0] dbg_streak
);

    state_t state, state_n;
    logic   grant_d, grant_if;
    logic   streak_inc, streak_clr, streak_max;

    // ---------------------------------------------------------------
    // FSM state register
    // ---------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // ---------------------------------------------------------------
    // Next state and grant decisions. Grants happen only from IDLE, so
    // request inputs seen while busy only matter for the stall outputs.
    // ---------------------------------------------------------------
    always_comb begin
        state_n  = state;
        grant_d  = 1'b0;
        grant_if = 1'b0;
        case (state)
            IDLE: begin
                // Data is preferred unless fetch has been passed over
                // MAX_DSTREAK times in a row.
                if (d_req && !(if_req && streak_max)) begin
                    grant_d = 1'b1;
                    state_n = D_BUSY;
                end else if (if_req) begin
                    grant_if = 1'b1;
                    state_n  = IF_BUSY;
                end
            end
            IF_BUSY, D_BUSY: begin
                if (mem_ack) begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // ---------------------------------------------------------------
    // Request latch, completion pulses and read-data capture
    // ---------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            if_ack    <= 1'b0;
            d_ack     <= 1'b0;
            if_rdata  <= '0;
            d_rdata   <= '0;
        end else begin
            if_ack <= 1'b0;
            d_ack  <= 1'b0;

            if (grant_d) begin
                mem_we    <= d_we;
                mem_addr  <= d_addr;
                mem_wdata <= d_wdata;
            end else if (grant_if) begin
                // mem_wdata is don't-care for a fetch; keep the old value.
                mem_we   <= 1'b0;
                mem_addr <= if_addr;
            end

            if (state == IF_BUSY && mem_ack) begin
                if_ack   <= 1'b1;
                if_rdata <= mem_rdata;
            end

            if (state == D_BUSY && mem_ack) begin
                d_ack <= 1'b1;
                // mem_we still holds the latched direction of this access.
                if (!mem_we) begin
                    d_rdata <= mem_rdata;
                end
            end
        end
    end

    // ---------------------------------------------------------------
    // Starvation streak: only data grants that actually made a fetch
    // wait extend the streak; anything else breaks it.
    // ---------------------------------------------------------------
    assign streak_inc = grant_d && if_req;
    assign streak_clr = grant_if || (grant_d && !if_req);

    mem_arb_streak #(
        .MAX (MAX_DSTREAK),
        .CW  (SW)
    ) u_streak (
        .clk    (clk),
        .rst    (rst),
        .inc    (streak_inc),
        .clr    (streak_clr),
        .at_max (streak_max),
        .count  (dbg_streak)
    );

    // ---------------------------------------------------------------
    // Outputs
    // ---------------------------------------------------------------
    assign mem_req   = (state != IDLE);
    assign if_stall  = if_req && !if_ack;
    assign d_stall   = d_req && !d_ack;
    assign dbg_state = state;

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter AW, default 32: address width.
REQ-002 Parameter DW, default 32: data width.
REQ-003 Parameter MAX_DSTREAK, default 4: max consecutive data grants while fetch waits.
REQ-004 clk  in  1  sole clock; all state updates on rising edge.
REQ-005 rst  in  1  reset, asynchronous, active-high.
REQ-006 if_req  in  1  fetch request; held until if_ack.
REQ-007 if_addr  in  AW  fetch address.
REQ-008 if_rdata  out  DW  fetch read data, valid with if_ack.
REQ-009 if_ack  out  1  one-cycle fetch completion pulse.
REQ-010 if_stall  out  1  stall to PC/IF-ID enable: if_req && !if_ack.
REQ-011 d_req  in  1  MEM-stage request; held until d_ack.
REQ-012 d_we  in  1  1 = store, 0 = load.
REQ-013 d_addr  in  AW  data address.
REQ-014 d_wdata  in  DW  store data.
REQ-015 d_rdata  out  DW  load data, valid with d_ack.
REQ-016 d_ack  out  1  one-cycle data completion pulse.
REQ-017 d_stall  out  1  stall to whole pipeline: d_req && !d_ack.
REQ-018 mem_req  out  1  memory request, held until mem_ack.
REQ-019 mem_we, mem_addr, mem_wdata  out  1/AW/DW  latched request fields.
REQ-020 mem_rdata  in  DW  memory read data, valid with mem_ack.
REQ-021 mem_ack  in  1  memory completion, variable latency >= 0 cycles after mem_req.

Function
REQ-022 FSM states IDLE, IF_BUSY, D_BUSY; mem_req = 1 exactly in IF_BUSY/D_BUSY.
REQ-023 IDLE: d_req && !(if_req && streak == MAX_DSTREAK) -> D_BUSY; else if_req -> IF_BUSY; else stay.
REQ-024 On grant, requester's addr/we/wdata latched into mem_* registers; fetch grants drive mem_we = 0.
REQ-025 BUSY state with mem_ack = 1 -> IDLE next edge; corresponding ack pulses high for exactly that next cycle.
REQ-026 Loads/fetches: rdata register loads mem_rdata on the mem_ack edge; stores leave d_rdata unchanged.
REQ-027 Minimum latency: req sampled edge N, mem_req high cycle N+1, ack high cycle N+2 if mem_ack is immediate.
REQ-028 One IDLE cycle always separates consecutive transactions; ack cycle coincides with that IDLE cycle.
REQ-029 Streak counter: increments (saturating at MAX_DSTREAK) on D grant with if_req = 1; clears on IF grant or on D grant with if_req = 0.
REQ-030 Simultaneous d_req and if_req with streak < MAX_DSTREAK: data wins.
REQ-031 Requester dropping req mid-transaction: transaction completes and ack still issued.
REQ-032 mem_ack in IDLE ignored; no state, ack or rdata change.
REQ-033 Request inputs ignored while BUSY except for stall generation.

Reset
REQ-034 rst asserted: state IDLE, mem_req 0, mem_we 0, mem_addr 0, mem_wdata 0, if_ack/d_ack 0, if_rdata/d_rdata 0, streak 0, immediately and asynchronously.
REQ-035 Reset mid-transaction abandons it; no ack issued after release; first grant from IDLE on first edge after deassertion.

Structure
REQ-036 Shared package mem_arb_pkg holds state enum encoding and default AW/DW/MAX_DSTREAK constants.
REQ-037 One sub-module, mem_arb_streak: saturating streak counter with inc/clr/at_max ports.

Verification
REQ-038 Fetch only: if_req, if_addr=0x100, mem_ack after 2 cycles with rdata 0x8C220004 -> if_ack one cycle, if_rdata 0x8C220004, if_stall low in ack cycle.
REQ-039 Contention: if_req and d_req (load, 0x2000) both high -> D granted first, mem_addr 0x2000, then IF granted after one IDLE cycle.
REQ-040 Starvation: d_req continuously high with fresh addresses, if_req high, MAX_DSTREAK=4 -> exactly 4 data grants, then 1 fetch grant.
REQ-041 Store: d_we=1, d_addr 0x40, d_wdata 0xDEADBEEF -> mem_we 1, mem_wdata 0xDEADBEEF, d_ack pulse, d_rdata unchanged.
REQ-042 Reset mid-D_BUSY: rst pulsed before mem_ack -> mem_req 0 immediately, no d_ack, streak 0.
REQ-043 Spurious mem_ack in IDLE and zero-latency mem_ack -> no ack in IDLE case; ack at N+2 in zero-latency case.
